// File: rtl/wb2core_no_ifs_pkg.sv
// Shared types for the Wishbone-to-core-memory bridge.
// The bridge FSM tracks whether it is idle, has transfers in flight, or is discarding responses after an abort.
package wb2core_no_ifs_pkg;

  typedef enum logic [1:0] {
    W2C_IDLE,
    W2C_ACTIVE,
    W2C_DRAIN
  } wb2core_state_t;

endpackage

// File: rtl/wb2core_no_ifs.sv
// Wishbone B4 pipelined slave that forwards requests to an Ibex-style req/gnt/rvalid memory port.
// Up to MAX_OUTSTANDING transfers may be in flight. Responses return as registered ack/err, and responses to an aborted cycle are drained.
module wb2core_no_ifs
  import wb2core_no_ifs_pkg::*;
#(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic            wb_we_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic [DW-1:0]   wb_dat_m_i,
  output logic            wb_stall_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic [DW-1:0]   wb_dat_s_o,
  output logic            core_req_o,
  input  logic            core_gnt_i,
  output logic            core_we_o,
  output logic [DW/8-1:0] core_be_o,
  output logic [AW-1:0]   core_addr_o,
  output logic [DW-1:0]   core_wdata_o,
  input  logic            core_rvalid_i,
  input  logic [DW-1:0]   core_rdata_i,
  input  logic            core_err_i
);

  localparam int            CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  wb2core_state_t state_q;
  logic [CW-1:0]  count_q;
  logic [CW-1:0]  count_d;
  logic           accept;
  logic           rsp_valid;
  logic           rsp_deliver;

  // The request side never looks at rvalid, so a full counter stalls even in a cycle where a slot frees up.
  assign core_req_o = ~rst & wb_cyc_i & wb_stb_i & (count_q < CNT_MAX) & (state_q != W2C_DRAIN);
  assign accept     = core_req_o & core_gnt_i;
  assign wb_stall_o = ~accept;

  assign core_addr_o  = wb_adr_i;
  assign core_we_o    = wb_we_i;
  assign core_be_o    = wb_sel_i;
  assign core_wdata_o = wb_dat_m_i;

  // A stray rvalid with nothing in flight is ignored entirely.
  assign rsp_valid   = core_rvalid_i & (count_q != '0);
  assign rsp_deliver = rsp_valid & wb_cyc_i & (state_q != W2C_DRAIN);

  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    count_d = count_q;
    unique case ({accept, rsp_valid})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= W2C_IDLE;
      count_q    <= '0;
      wb_ack_o   <= 1'b0;
      wb_err_o   <= 1'b0;
      wb_dat_s_o <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register here see the pre-edge values, whatever the statement order.
      count_q  <= count_d;
      wb_ack_o <= rsp_deliver & ~core_err_i;
      wb_err_o <= rsp_deliver &  core_err_i;
      if (rsp_valid) begin
        wb_dat_s_o <= core_rdata_i;
      end

      unique case (state_q)
        W2C_IDLE: begin
          if (accept) begin
            state_q <= W2C_ACTIVE;
          end
        end
        W2C_ACTIVE: begin
          if (!wb_cyc_i) begin
            state_q <= (count_d != '0) ? W2C_DRAIN : W2C_IDLE;
          end else if (count_d == '0) begin
            state_q <= W2C_IDLE;
          end
        end
        W2C_DRAIN: begin
          if (count_d == '0) begin
            state_q <= W2C_IDLE;
          end
        end
        default: state_q <= W2C_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb2core_no_ifs.sv
// Directed bench for wb2core_no_ifs. The stimulus pushes expected responses into a scoreboard,
// and a negedge monitor pops one entry for each ack/err the bridge presents.
module tb_wb2core_no_ifs;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_cyc, wb_stb, wb_we;
  logic [AW-1:0] wb_adr;
  logic [SW-1:0] wb_sel;
  logic [DW-1:0] wb_dat_m;
  logic          wb_stall, wb_ack, wb_err;
  logic [DW-1:0] wb_dat_s;
  logic          core_req, core_gnt, core_we;
  logic [SW-1:0] core_be;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          core_err;

  always #5 clk = ~clk;

  wb2core_no_ifs #(.AW(AW), .DW(DW), .MAX_OUTSTANDING(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_cyc_i     (wb_cyc),
    .wb_stb_i     (wb_stb),
    .wb_we_i      (wb_we),
    .wb_adr_i     (wb_adr),
    .wb_sel_i     (wb_sel),
    .wb_dat_m_i   (wb_dat_m),
    .wb_stall_o   (wb_stall),
    .wb_ack_o     (wb_ack),
    .wb_err_o     (wb_err),
    .wb_dat_s_o   (wb_dat_s),
    .core_req_o   (core_req),
    .core_gnt_i   (core_gnt),
    .core_we_o    (core_we),
    .core_be_o    (core_be),
    .core_addr_o  (core_addr),
    .core_wdata_o (core_wdata),
    .core_rvalid_i(core_rvalid),
    .core_rdata_i (core_rdata),
    .core_err_i   (core_err)
  );

  typedef struct packed {
    logic          err;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t exp_head;
  int   tests      = 0;
  int   fails      = 0;
  int   rsp_pushed = 0;
  int   rsp_seen   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_rsp(input logic e, input logic [DW-1:0] d);
    exp_q.push_back({e, d});
    rsp_pushed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = '0; wb_sel = '0; wb_dat_m = '0;
    core_gnt = 0; core_rvalid = 0; core_rdata = '0; core_err = 0;
  endtask

  // Scoreboard monitor: every ack/err must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && (wb_ack || wb_err)) begin
      rsp_seen++;
      check("ack_err_exclusive", 64'(wb_ack & wb_err), 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_response", 64'(wb_dat_s), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_head = exp_q.pop_front();
        check("rsp_err", 64'(wb_err), 64'(exp_head.err));
        check("rsp_data", 64'(wb_dat_s), 64'(exp_head.data));
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    sample();
    check("reset_ack", 64'(wb_ack), 0);
    check("reset_err", 64'(wb_err), 0);
    check("reset_dat", 64'(wb_dat_s), 0);
    check("reset_stall", 64'(wb_stall), 1);
    check("reset_req", 64'(core_req), 0);
    step();
    rst = 1'b0;
    step();

    // Single read with the response two cycles after the grant.
    wb_cyc = 1; wb_stb = 1; wb_adr = 32'h100; wb_sel = 4'hF; core_gnt = 1;
    sample();
    check("rd_stall_accept", 64'(wb_stall), 0);
    check("rd_req", 64'(core_req), 1);
    check("rd_addr", 64'(core_addr), 64'h100);
    check("rd_we", 64'(core_we), 0);
    check("rd_be", 64'(core_be), 64'hF);
    step();
    wb_stb = 0; core_gnt = 0;
    sample();
    check("rd_stall_after", 64'(wb_stall), 1);
    step();
    core_rvalid = 1; core_rdata = 32'hDEADBEEF; expect_rsp(1'b0, 32'hDEADBEEF);
    sample();
    check("rd_ack_not_early", 64'(wb_ack), 0);
    step();
    core_rvalid = 0;
    sample();
    check("rd_ack", 64'(wb_ack), 1);
    check("rd_dat", 64'(wb_dat_s), 64'hDEADBEEF);
    step();
    sample();
    check("rd_ack_pulse", 64'(wb_ack), 0);
    check("rd_dat_held", 64'(wb_dat_s), 64'hDEADBEEF);
    wb_cyc = 0;
    step();

    // Four pipelined writes, each answered one cycle after its grant.
    wb_cyc = 1; wb_we = 1; wb_sel = 4'h3; core_gnt = 1;
    for (int i = 0; i < 5; i++) begin
      wb_stb   = (i < 4);
      core_gnt = (i < 4);
      wb_adr   = 32'h200 + 32'(4 * i);
      wb_dat_m = 32'h1000 + 32'(i);
      core_rvalid = (i > 0);
      core_rdata  = 32'hA0 + 32'(i);
      if (i > 0) expect_rsp(1'b0, 32'hA0 + 32'(i));
      sample();
      if (i < 4) begin
        check("wr_no_stall", 64'(wb_stall), 0);
        check("wr_wdata", 64'(core_wdata), 64'(32'h1000 + 32'(i)));
        check("wr_we", 64'(core_we), 1);
        check("wr_be", 64'(core_be), 64'h3);
      end
      step();
    end
    core_rvalid = 0;
    sample();
    step();
    wb_cyc = 0; wb_we = 0;
    step();

    // Response withheld: exactly two accepts, then stall until the cycle after the first rvalid.
    wb_cyc = 1; wb_stb = 1; wb_adr = 32'h300; wb_sel = 4'hF; core_gnt = 1;
    for (int i = 0; i < 6; i++) begin
      core_rvalid = (i == 5);
      core_rdata  = 32'h11;
      if (i == 5) expect_rsp(1'b0, 32'h11);
      sample();
      check("full_stall", 64'(wb_stall), (i >= 2) ? 64'd1 : 64'd0);
      check("full_req", 64'(core_req), (i < 2) ? 64'd1 : 64'd0);
      step();
    end
    core_rvalid = 0;
    sample();
    check("full_resume_stall", 64'(wb_stall), 0);
    check("full_resume_req", 64'(core_req), 1);
    step();
    wb_stb = 0; core_gnt = 0;
    core_rvalid = 1; core_rdata = 32'h22; expect_rsp(1'b0, 32'h22);
    sample();
    step();
    core_rdata = 32'h33; expect_rsp(1'b0, 32'h33);
    sample();
    step();
    core_rvalid = 0;
    sample();
    step();
    wb_cyc = 0;
    step();

    // Error response.
    wb_cyc = 1; wb_stb = 1; wb_adr = 32'h400; core_gnt = 1;
    sample();
    step();
    wb_stb = 0; core_gnt = 0;
    core_rvalid = 1; core_err = 1; core_rdata = 32'hBAD00001; expect_rsp(1'b1, 32'hBAD00001);
    sample();
    step();
    core_rvalid = 0; core_err = 0;
    sample();
    check("err_pulse", 64'(wb_err), 1);
    check("err_no_ack", 64'(wb_ack), 0);
    step();
    sample();
    check("err_one_cycle", 64'(wb_err), 0);
    wb_cyc = 0;
    step();

    // Abort with two outstanding: cycle drops, drain silently, then accept again.
    wb_cyc = 1; wb_stb = 1; wb_adr = 32'h500; core_gnt = 1;
    sample();
    step();
    sample();
    step();
    wb_cyc = 0; wb_stb = 0;
    sample();
    check("abort_req_low", 64'(core_req), 0);
    step();
    wb_cyc = 1; wb_stb = 1;
    sample();
    check("drain_stall", 64'(wb_stall), 1);
    check("drain_req", 64'(core_req), 0);
    step();
    core_rvalid = 1; core_rdata = 32'h55;
    sample();
    check("drain_stall_rv1", 64'(wb_stall), 1);
    step();
    core_rdata = 32'h66;
    sample();
    check("drain_stall_rv2", 64'(wb_stall), 1);
    check("drain_no_ack1", 64'(wb_ack), 0);
    step();
    core_rvalid = 0;
    sample();
    check("drain_no_ack2", 64'(wb_ack), 0);
    check("post_drain_stall", 64'(wb_stall), 0);
    check("post_drain_req", 64'(core_req), 1);
    step();
    wb_stb = 0; core_gnt = 0;
    core_rvalid = 1; core_rdata = 32'h77; expect_rsp(1'b0, 32'h77);
    sample();
    step();
    core_rvalid = 0;
    sample();
    check("post_drain_ack", 64'(wb_ack), 1);
    check("post_drain_dat", 64'(wb_dat_s), 64'h77);
    step();
    wb_cyc = 0;
    step();

    // Reset in flight: outputs clear at once and a late rvalid is ignored.
    wb_cyc = 1; wb_stb = 1; wb_adr = 32'h600; core_gnt = 1;
    sample();
    step();
    sample();
    step();
    wb_stb = 0; core_gnt = 0;
    core_rvalid = 1; core_rdata = 32'hCAFE0001;
    sample();
    step();
    core_rvalid = 0; wb_stb = 1; core_gnt = 1;
    rst = 1;
    #1;
    check("rst_mid_ack", 64'(wb_ack), 0);
    check("rst_mid_err", 64'(wb_err), 0);
    check("rst_mid_dat", 64'(wb_dat_s), 0);
    check("rst_mid_stall", 64'(wb_stall), 1);
    check("rst_mid_req", 64'(core_req), 0);
    sample();
    step();
    wb_stb = 0; core_gnt = 0;
    rst = 0;
    core_rvalid = 1; core_rdata = 32'hDEAD0002;
    sample();
    step();
    core_rvalid = 0;
    sample();
    check("rst_stray_no_ack", 64'(wb_ack), 0);
    check("rst_stray_no_err", 64'(wb_err), 0);
    step();
    wb_stb = 1; core_gnt = 1;
    sample();
    check("rst_after_req", 64'(core_req), 1);
    check("rst_after_stall", 64'(wb_stall), 0);
    step();
    wb_stb = 0; core_gnt = 0;
    core_rvalid = 1; core_rdata = 32'h600D; expect_rsp(1'b0, 32'h600D);
    sample();
    step();
    core_rvalid = 0;
    sample();
    step();
    wb_cyc = 0;
    step();
    sample();

    check("scoreboard_empty", 64'(exp_q.size()), 0);
    check("response_count", 64'(rsp_seen), 64'(rsp_pushed));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
